// File: rtl/cpu_trace_pkg.sv
// Shared types and constants for the commit trace path between the core and the reference checker.
package cpu_trace_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rd;
        logic [31:0] rs;
        logic [31:0] rt;
    } trace_rec_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } trc_state_e;

    localparam logic [31:0] TRC_HALT_INSTR = 32'h0000000c;
    localparam logic [31:0] TRC_HALT_V0    = 32'h0000000a;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of commit records with a registered head output.
module trace_fifo
    import cpu_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  trace_rec_t  din,
    input  logic        pop,
    output trace_rec_t  dout,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level
);

    trace_rec_t   mem [DEPTH];
    trace_rec_t   head_q;
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW:0]  rd_nxt;
    logic         push_ok;
    logic         pop_ok;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (level == (AW + 1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A pop frees the slot the push writes into, so full + push + pop is legal.
    assign push_ok = push && (!full || pop_ok);
    assign rd_nxt  = rd_ptr + {{AW{1'b0}}, pop_ok};
    assign dout    = head_q;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Head register reloads only when the head moves or the first record lands;
    // the incoming record is bypassed when it becomes the new head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_nxt;
            if (pop_ok || (empty && push_ok))
                head_q <= (push_ok && rd_nxt == wr_ptr) ? din : mem[rd_nxt[AW-1:0]];
        end
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// Buffers per-instruction commit records for the reference checker and detects the exit syscall.
module commit_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int          DEPTH      = 16,
    parameter logic [31:0] HALT_INSTR = TRC_HALT_INSTR,
    parameter logic [31:0] HALT_V0    = TRC_HALT_V0,
    parameter int          LW         = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmt_valid,
    input  logic [31:0]   cmt_pc,
    input  logic [31:0]   cmt_instr,
    input  logic [31:0]   cmt_rd,
    input  logic [31:0]   cmt_rs,
    input  logic [31:0]   cmt_rt,
    input  logic [31:0]   cmt_v0,
    input  logic          trc_ready,
    output logic          trc_valid,
    output logic [159:0]  trc_rec,
    output logic [LW-1:0] level,
    output logic [31:0]   commit_count,
    output logic          overflow,
    output logic          halted
);

    trc_state_e state, state_nxt;
    trace_rec_t din, dout;
    logic       push_req;
    logic       pop;
    logic       is_halt;
    logic       full;
    logic       empty;

    assign push_req  = cmt_valid && (state == RUN);
    assign is_halt   = push_req && (cmt_instr == HALT_INSTR) && (cmt_v0 == HALT_V0);
    assign pop       = trc_valid && trc_ready;
    assign trc_valid = !empty;
    assign trc_rec   = dout;
    assign din       = '{pc: cmt_pc, instr: cmt_instr, rd: cmt_rd, rs: cmt_rs, rt: cmt_rt};

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .din   (din),
        .pop   (trc_ready),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    // Drain completes when the occupancy left after this cycle's pop is zero.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (is_halt) state_nxt = DRAIN;
            DRAIN:   if (level == LW'(pop)) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commit_count <= '0;
            overflow     <= 1'b0;
            halted       <= 1'b0;
        end else begin
            if (push_req && commit_count != '1) commit_count <= commit_count + 1'b1;
            if (push_req && full && !pop)        overflow     <= 1'b1;
            halted <= (state == DONE);
        end
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed self-checking bench for commit_trace_buffer.
module tb_commit_trace_buffer;
    import cpu_trace_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmt_valid;
    logic [31:0]  cmt_pc, cmt_instr, cmt_rd, cmt_rs, cmt_rt, cmt_v0;
    logic         trc_ready;
    logic         trc_valid;
    logic [159:0] trc_rec;
    logic [4:0]   level;
    logic [31:0]  commit_count;
    logic         overflow;
    logic         halted;

    int n_checks = 0;
    int n_fail   = 0;

    commit_trace_buffer #(.DEPTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmt_valid    (cmt_valid),
        .cmt_pc       (cmt_pc),
        .cmt_instr    (cmt_instr),
        .cmt_rd       (cmt_rd),
        .cmt_rs       (cmt_rs),
        .cmt_rt       (cmt_rt),
        .cmt_v0       (cmt_v0),
        .trc_ready    (trc_ready),
        .trc_valid    (trc_valid),
        .trc_rec      (trc_rec),
        .level        (level),
        .commit_count (commit_count),
        .overflow     (overflow),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [159:0] mkrec(input logic [31:0] pc, input logic [31:0] instr);
        return {pc, instr, pc ^ 32'ha5a50000, pc + 32'h10, pc + 32'h20};
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [31:0] v0);
        cmt_valid = v;
        cmt_pc    = pc;
        cmt_instr = instr;
        cmt_rd    = pc ^ 32'ha5a50000;
        cmt_rs    = pc + 32'h10;
        cmt_rt    = pc + 32'h20;
        cmt_v0    = v0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        trc_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // Reset values
        do_reset();
        chk("rst_valid", 160'(trc_valid), 160'(1'b0));
        chk("rst_rec", trc_rec, 160'(0));
        chk("rst_level", 160'(level), 160'(0));
        chk("rst_count", 160'(commit_count), 160'(0));
        chk("rst_ovf", 160'(overflow), 160'(1'b0));
        chk("rst_halted", 160'(halted), 160'(1'b0));

        // Three commits streamed through with ready held high
        trc_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h00400000 + 32'(4 * i), 32'h20080000 + 32'(i), 32'h0);
            @(negedge clk);
            chk("t1_valid", 160'(trc_valid), 160'(1'b1));
            chk("t1_rec", trc_rec, mkrec(32'h00400000 + 32'(4 * i), 32'h20080000 + 32'(i)));
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t1_level", 160'(level), 160'(0));
        chk("t1_valid_end", 160'(trc_valid), 160'(1'b0));
        chk("t1_count", 160'(commit_count), 160'(3));

        // Twenty commits against a stalled checker: 16 kept, 4 dropped
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h00001000 + 32'(4 * i), 32'h01000000 + 32'(i), 32'h0);
            @(negedge clk);
            if (i == 15) begin
                chk("t2_level16", 160'(level), 160'(16));
                chk("t2_ovf_at16", 160'(overflow), 160'(1'b0));
            end
            if (i == 16) chk("t2_ovf_at17", 160'(overflow), 160'(1'b1));
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        chk("t2_level", 160'(level), 160'(16));
        chk("t2_count", 160'(commit_count), 160'(20));
        trc_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk("t2_drain_valid", 160'(trc_valid), 160'(1'b1));
            chk("t2_drain_rec", trc_rec, mkrec(32'h00001000 + 32'(4 * k), 32'h01000000 + 32'(k)));
            @(negedge clk);
        end
        chk("t2_empty", 160'(trc_valid), 160'(1'b0));
        chk("t2_ovf_sticky", 160'(overflow), 160'(1'b1));

        // Full FIFO with simultaneous push and pop
        do_reset();
        chk("t3_ovf_cleared", 160'(overflow), 160'(1'b0));
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'h00002000 + 32'(4 * i), 32'h02000000 + 32'(i), 32'h0);
            @(negedge clk);
        end
        chk("t3_full", 160'(level), 160'(16));
        drive(1'b1, 32'h00002040, 32'h02000010, 32'h0);
        trc_ready = 1'b1;
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        chk("t3_level_pp", 160'(level), 160'(16));
        chk("t3_no_ovf", 160'(overflow), 160'(1'b0));
        for (int k = 1; k < 17; k++) begin
            chk("t3_drain_rec", trc_rec, mkrec(32'h00002000 + 32'(4 * k), 32'h02000000 + 32'(k)));
            @(negedge clk);
        end
        chk("t3_level_end", 160'(level), 160'(0));

        // Exit syscall behind five queued records
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h00003000 + 32'(4 * i), 32'h03000000 + 32'(i), 32'h0);
            @(negedge clk);
        end
        drive(1'b1, 32'h00003014, 32'h0000000c, 32'h0000000a);
        @(negedge clk);
        chk("t4_level6", 160'(level), 160'(6));
        drive(1'b1, 32'h00009000, 32'h0000000c, 32'h0000000a);
        trc_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("t4_rec", trc_rec, (k < 5) ? mkrec(32'h00003000 + 32'(4 * k), 32'h03000000 + 32'(k))
                                           : mkrec(32'h00003014, 32'h0000000c));
            chk("t4_not_halted", 160'(halted), 160'(1'b0));
            @(negedge clk);
        end
        chk("t4_level0", 160'(level), 160'(0));
        chk("t4_valid0", 160'(trc_valid), 160'(1'b0));
        chk("t4_halted_late", 160'(halted), 160'(1'b0));
        @(negedge clk);
        chk("t4_halted", 160'(halted), 160'(1'b1));
        chk("t4_count", 160'(commit_count), 160'(6));
        chk("t4_ignored", 160'(level), 160'(0));
        drive(1'b0, 32'h0, 32'h0, 32'h0);

        // Syscall with v0 != 10 is an ordinary commit
        do_reset();
        trc_ready = 1'b1;
        drive(1'b1, 32'h00005000, 32'h0000000c, 32'h00000004);
        @(negedge clk);
        chk("t5_rec", trc_rec, mkrec(32'h00005000, 32'h0000000c));
        drive(1'b1, 32'h00005004, 32'h00000000, 32'h0000000a);
        @(negedge clk);
        chk("t5_rec2", trc_rec, mkrec(32'h00005004, 32'h00000000));
        chk("t5_level", 160'(level), 160'(1));
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t5_count", 160'(commit_count), 160'(2));
        @(negedge clk);
        chk("t5_halted", 160'(halted), 160'(1'b0));

        // Asynchronous reset in the middle of a drain
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h00006000 + 32'(4 * i), 32'h06000000 + 32'(i), 32'h0);
            @(negedge clk);
        end
        drive(1'b1, 32'h00006018, 32'h0000000c, 32'h0000000a);
        @(negedge clk);
        drive(1'b1, 32'h00006100, 32'h06000100, 32'h0);
        @(negedge clk);
        chk("t6_level7", 160'(level), 160'(7));
        reset = 1'b1;
        #1;
        chk("t6_level", 160'(level), 160'(0));
        chk("t6_valid", 160'(trc_valid), 160'(1'b0));
        chk("t6_halted", 160'(halted), 160'(1'b0));
        chk("t6_ovf", 160'(overflow), 160'(1'b0));
        chk("t6_count", 160'(commit_count), 160'(0));
        @(negedge clk);
        reset = 1'b0;
        trc_ready = 1'b1;
        drive(1'b1, 32'h00007000, 32'h07000000, 32'h0);
        @(negedge clk);
        chk("t6_post_valid", 160'(trc_valid), 160'(1'b1));
        chk("t6_post_rec", trc_rec, mkrec(32'h00007000, 32'h07000000));
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t6_post_count", 160'(commit_count), 160'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
